spi_slave_param: RTL and testbench

SPI_SLAVE_PARAM -- requirements
Module: spi_slave_param

---
 rtl/spi_slave_param.sv | 174 +++++++++++++++++
 tb/tb_spi_slave_param.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_param.sv
// spi_slave_param: SPI slave with a one-word TX buffer and a single-entry RX holding register.
// Optional macro SPI_SLAVE_SYNC_EN adds a synchronizer flop ahead of each input sampling register.
module spi_slave_param #(
    parameter int DW        = 16,
    parameter int CPOL      = 0,
    parameter int CPHA      = 0,
    parameter int MSB_FIRST = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sclk,
    input  logic          ssn,
    input  logic          mosi,
    output logic          miso,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_load,
    output logic          tx_ready,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          overrun,
    output logic          busy
);
    localparam int            CW             = $clog2(DW);
    localparam logic [CW-1:0] LAST           = CW'(DW - 1);
    localparam logic          SCLK_IDLE      = (CPOL != 0);
    localparam logic          SAMPLE_ON_RISE = ((CPOL != 0) == (CPHA != 0));

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] rx_shift_q, tx_shift_q, rx_data_q, buf_q;
    logic          rx_valid_q, overrun_q, miso_q, buf_full_q, skip_q;
    logic          sclk_q, sclk_prev_q, ssn_q, ssn_prev_q, mosi_q;
    logic          sclk_in, ssn_in, mosi_in;

    function automatic logic head_bit(input logic [DW-1:0] w);
        return (MSB_FIRST != 0) ? w[DW-1] : w[0];
    endfunction

    function automatic logic [DW-1:0] advance(input logic [DW-1:0] w);
        return (MSB_FIRST != 0) ? {w[DW-2:0], 1'b0} : {1'b0, w[DW-1:1]};
    endfunction

`ifdef SPI_SLAVE_SYNC_EN
    logic sclk_sync_q, ssn_sync_q, mosi_sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= SCLK_IDLE;
            ssn_sync_q  <= 1'b1;
            mosi_sync_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk;
            ssn_sync_q  <= ssn;
            mosi_sync_q <= mosi;
        end
    end

    assign sclk_in = sclk_sync_q;
    assign ssn_in  = ssn_sync_q;
    assign mosi_in = mosi_sync_q;
`else
    assign sclk_in = sclk;
    assign ssn_in  = ssn;
    assign mosi_in = mosi;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q      <= SCLK_IDLE;
            sclk_prev_q <= SCLK_IDLE;
            ssn_q       <= 1'b1;
            ssn_prev_q  <= 1'b1;
            mosi_q      <= 1'b0;
        end else begin
            sclk_q      <= sclk_in;
            sclk_prev_q <= sclk_q;
            ssn_q       <= ssn_in;
            ssn_prev_q  <= ssn_q;
            mosi_q      <= mosi_in;
        end
    end

    logic          sclk_rise, sclk_fall, ssn_fall, ssn_rise, sample_edge, shift_edge;
    logic          wrap, word_start;
    logic [DW-1:0] rx_shift_d, tx_word_d;

    assign sclk_rise   = sclk_q & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_q & sclk_prev_q;
    assign ssn_fall    = ~ssn_q & ssn_prev_q;
    assign ssn_rise    = ssn_q & ~ssn_prev_q;
    assign sample_edge = SAMPLE_ON_RISE ? sclk_rise : sclk_fall;
    assign shift_edge  = SAMPLE_ON_RISE ? sclk_fall : sclk_rise;
    assign rx_shift_d  = (MSB_FIRST != 0) ? {rx_shift_q[DW-2:0], mosi_q} : {mosi_q, rx_shift_q[DW-1:1]};
    assign tx_word_d   = buf_full_q ? buf_q : '0;
    assign wrap        = (state_q == S_ACTIVE) && sample_edge && (cnt_q == LAST);
    assign word_start  = ((state_q == S_IDLE) && ssn_fall) || (wrap && !ssn_q);

    // With CPHA=0 a back-to-back word already shows its first bit at the wrap,
    // so the trailing shift edge of the previous word must not advance it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            miso_q     <= 1'b0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            skip_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    miso_q <= 1'b0;
                    cnt_q  <= '0;
                    skip_q <= 1'b0;
                    if (ssn_fall) state_q <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (sample_edge) begin
                        rx_shift_q <= rx_shift_d;
                        cnt_q      <= wrap ? '0 : cnt_q + 1'b1;
                        if (wrap) begin
                            rx_data_q  <= rx_shift_d;
                            rx_valid_q <= 1'b1;
                            overrun_q  <= rx_valid_q && !rx_ready;
                        end
                    end else if (shift_edge) begin
                        if (skip_q) begin
                            skip_q <= 1'b0;
                        end else begin
                            miso_q     <= head_bit(tx_shift_q);
                            tx_shift_q <= advance(tx_shift_q);
                        end
                    end
                    if (ssn_rise) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                        miso_q  <= 1'b0;
                        skip_q  <= 1'b0;
                    end
                end
            endcase
            if (word_start) begin
                buf_full_q <= 1'b0;
                if (CPHA == 0) begin
                    miso_q     <= head_bit(tx_word_d);
                    tx_shift_q <= advance(tx_word_d);
                    skip_q     <= (state_q == S_ACTIVE);
                end else begin
                    tx_shift_q <= tx_word_d;
                end
            end
            if (tx_load && !buf_full_q) begin
                buf_q      <= tx_data;
                buf_full_q <= 1'b1;
            end
        end
    end

    assign miso     = miso_q;
    assign tx_ready = ~buf_full_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign overrun  = overrun_q;
    assign busy     = (state_q == S_ACTIVE);
endmodule

// File: tb/tb_spi_slave_param.sv
// Bench for spi_slave_param: a mode-0 16-bit MSB-first instance and a mode-3 8-bit LSB-first instance.
module tb_spi_slave_param;
    localparam int H = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sclk0 = 1'b0, ssn0 = 1'b1, mosi0 = 1'b0, txl0 = 1'b0, rxr0 = 1'b0;
    logic [15:0] txd0 = '0;
    logic        miso0, txr0, rxv0, ovr0, busy0;
    logic [15:0] rxd0;

    logic        sclk3 = 1'b1, ssn3 = 1'b1, mosi3 = 1'b0, txl3 = 1'b0, rxr3 = 1'b1;
    logic [7:0]  txd3 = '0;
    logic        miso3, txr3, rxv3, ovr3, busy3;
    logic [7:0]  rxd3;

    spi_slave_param #(.DW(16), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset), .sclk(sclk0), .ssn(ssn0), .mosi(mosi0), .miso(miso0),
        .tx_data(txd0), .tx_load(txl0), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0),
        .rx_ready(rxr0), .overrun(ovr0), .busy(busy0));

    spi_slave_param #(.DW(8), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) dut3 (
        .clk(clk), .reset(reset), .sclk(sclk3), .ssn(ssn3), .mosi(mosi3), .miso(miso3),
        .tx_data(txd3), .tx_load(txl3), .tx_ready(txr3), .rx_data(rxd3), .rx_valid(rxv3),
        .rx_ready(rxr3), .overrun(ovr3), .busy(busy3));

    int errs = 0;
    int checks = 0;
    int ovr_cnt0 = 0, ovr_cnt3 = 0, txr_low0 = 0;
    logic [15:0] rxq0[$];
    logic [7:0]  rxq3[$];

    always @(posedge clk) begin
        if (ovr0) ovr_cnt0 <= ovr_cnt0 + 1;
        if (ovr3) ovr_cnt3 <= ovr_cnt3 + 1;
        if (!txr0) txr_low0 <= txr_low0 + 1;
        if (rxv0 && rxr0) rxq0.push_back(rxd0);
        if (rxv3 && rxr3) rxq3.push_back(rxd3);
    end

    typedef struct {
        logic [15:0] mosi;
        logic [15:0] tx;
        bit          load;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t        tbl[5];
    logic [15:0] f_mosi[4];
    logic [15:0] f_tx[4];
    bit          f_load[4];
    logic [15:0] f_miso[4];
    logic [15:0] exp_q[$];

    task automatic ck(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load0(input logic [15:0] v);
        txd0 = v;
        txl0 = 1'b1;
        ck(1);
        txl0 = 1'b0;
    endtask

    task automatic load3(input logic [7:0] v);
        txd3 = v;
        txl3 = 1'b1;
        ck(1);
        txl3 = 1'b0;
    endtask

    task automatic consume0();
        rxr0 = 1'b1;
        ck(1);
        rxr0 = 1'b0;
        ck(1);
    endtask

    // Mode-0 master: mosi/miso exchanged MSB first, miso sampled just before each rising sclk.
    task automatic frame0(input int nw, input bit ssn_on_last);
        if (f_load[0]) load0(f_tx[0]);
        ssn0 = 1'b0;
        ck(H);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 16; b++) begin
                mosi0 = f_mosi[w][15 - b];
                if (b == 2 && w + 1 < nw && f_load[w + 1]) begin
                    load0(f_tx[w + 1]);
                    ck(H - 1);
                end else begin
                    ck(H);
                end
                f_miso[w][15 - b] = miso0;
                sclk0 = 1'b1;
                if (ssn_on_last && w == nw - 1 && b == 15) ssn0 = 1'b1;
                ck(H);
                sclk0 = 1'b0;
            end
        end
        ck(H);
        ssn0  = 1'b1;
        mosi0 = 1'b0;
        ck(8);
    endtask

    task automatic partial0(input int nbits, input logic [15:0] word);
        ssn0 = 1'b0;
        ck(H);
        for (int b = 0; b < nbits; b++) begin
            mosi0 = word[15 - b];
            ck(H);
            sclk0 = 1'b1;
            ck(H);
            sclk0 = 1'b0;
        end
        ck(H);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          nw;
        int          ob;
        int          tl;
        logic [7:0]  m3[2];
        logic [7:0]  r3[2];
        logic [15:0] em;

        tbl[0] = '{16'hA5C3, 16'h3C5A, 1'b1, 16'hA5C3, 16'h3C5A};
        tbl[1] = '{16'h1234, 16'hFFFF, 1'b0, 16'h1234, 16'h0000};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b1, 16'hFFFF, 16'h0001};
        tbl[3] = '{16'h0000, 16'h8000, 1'b1, 16'h0000, 16'h8000};
        tbl[4] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE};
        m3[0] = 8'h81;
        m3[1] = 8'h7E;

        ck(3);
        check("reset miso", 32'(miso0), 32'd0);
        check("reset tx_ready", 32'(txr0), 32'd1);
        check("reset rx_valid", 32'(rxv0), 32'd0);
        check("reset rx_data", 32'(rxd0), 32'd0);
        check("reset overrun", 32'(ovr0), 32'd0);
        check("reset busy", 32'(busy0), 32'd0);
        reset = 1'b0;
        ck(3);

        for (int i = 0; i < 5; i++) begin
            f_mosi[0] = tbl[i].mosi;
            f_tx[0]   = tbl[i].tx;
            f_load[0] = tbl[i].load;
            frame0(1, 1'b0);
            check("tbl rx_data", 32'(rxd0), 32'(tbl[i].exp_rx));
            check("tbl rx_valid", 32'(rxv0), 32'd1);
            check("tbl miso word", 32'(f_miso[0]), 32'(tbl[i].exp_miso));
            check("tbl tx_ready", 32'(txr0), 32'd1);
            check("tbl busy idle", 32'(busy0), 32'd0);
            check("tbl miso idle", 32'(miso0), 32'd0);
            consume0();
            check("tbl rx_valid cleared", 32'(rxv0), 32'd0);
        end

        ob = ovr_cnt0;
        f_mosi[0] = 16'h1111; f_mosi[1] = 16'h2222;
        f_load[0] = 1'b0;     f_load[1] = 1'b0;
        frame0(2, 1'b0);
        check("overrun pulses", 32'(ovr_cnt0 - ob), 32'd1);
        check("overrun rx_data", 32'(rxd0), 32'h2222);
        check("overrun rx_valid", 32'(rxv0), 32'd1);
        consume0();

        ob = ovr_cnt0;
        partial0(9, 16'hF0F0);
        check("partial busy", 32'(busy0), 32'd1);
        ssn0 = 1'b1;
        ck(6);
        check("partial rx_valid", 32'(rxv0), 32'd0);
        check("partial busy fall", 32'(busy0), 32'd0);
        check("partial overrun", 32'(ovr_cnt0 - ob), 32'd0);
        f_mosi[0] = 16'h1234; f_load[0] = 1'b0;
        frame0(1, 1'b0);
        check("after partial rx_data", 32'(rxd0), 32'h1234);
        check("after partial rx_valid", 32'(rxv0), 32'd1);
        consume0();

        f_mosi[0] = 16'h5AA5; f_load[0] = 1'b0;
        frame0(1, 1'b1);
        check("ssn+done rx_data", 32'(rxd0), 32'h5AA5);
        check("ssn+done rx_valid", 32'(rxv0), 32'd1);
        check("ssn+done busy", 32'(busy0), 32'd0);
        consume0();

        tl = txr_low0;
        f_mosi[0] = 16'hC001; f_mosi[1] = 16'h0FF0;
        f_load[0] = 1'b0;     f_load[1] = 1'b0;
        frame0(2, 1'b0);
        check("empty buf miso w0", 32'(f_miso[0]), 32'd0);
        check("empty buf miso w1", 32'(f_miso[1]), 32'd0);
        check("empty buf tx_ready low cycles", 32'(txr_low0 - tl), 32'd0);
        consume0();
        load0(16'h1357);
        check("load drops tx_ready", 32'(txr0), 32'd0);
        load0(16'h2468);
        f_mosi[0] = 16'h0F0F; f_load[0] = 1'b0;
        frame0(1, 1'b0);
        check("ignored load miso", 32'(f_miso[0]), 32'h1357);
        check("ignored load tx_ready", 32'(txr0), 32'd1);
        consume0();

        f_mosi[0] = 16'h4444; f_load[0] = 1'b0;
        frame0(1, 1'b0);
        load0(16'hFFFF);
        ssn0 = 1'b0;
        ck(H);
        for (int b = 0; b < 5; b++) begin
            mosi0 = 1'b1;
            if (b == 2) begin
                load0(16'h7777);
                ck(H - 1);
            end else begin
                ck(H);
            end
            sclk0 = 1'b1;
            ck(H);
            sclk0 = 1'b0;
        end
        ck(2);
        check("pre-reset busy", 32'(busy0), 32'd1);
        check("pre-reset tx_ready", 32'(txr0), 32'd0);
        check("pre-reset rx_valid", 32'(rxv0), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("mid reset busy", 32'(busy0), 32'd0);
        check("mid reset miso", 32'(miso0), 32'd0);
        check("mid reset tx_ready", 32'(txr0), 32'd1);
        check("mid reset rx_valid", 32'(rxv0), 32'd0);
        check("mid reset rx_data", 32'(rxd0), 32'd0);
        ssn0  = 1'b1;
        mosi0 = 1'b0;
        ck(2);
        reset = 1'b0;
        ck(3);
        check("post reset busy", 32'(busy0), 32'd0);
        f_mosi[0] = 16'hBEEF; f_tx[0] = 16'hABCD; f_load[0] = 1'b1;
        frame0(1, 1'b0);
        check("post reset rx_data", 32'(rxd0), 32'hBEEF);
        check("post reset miso", 32'(f_miso[0]), 32'hABCD);
        consume0();

        rxq3.delete();
        ob = ovr_cnt3;
        load3(8'h5A);
        ssn3 = 1'b0;
        ck(H);
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 8; b++) begin
                sclk3 = 1'b0;
                mosi3 = m3[w][b];
                if (w == 0 && b == 2) begin
                    load3(8'hC3);
                    ck(H - 1);
                end else begin
                    ck(H);
                end
                r3[w][b] = miso3;
                sclk3 = 1'b1;
                ck(H);
            end
        end
        ck(H);
        ssn3 = 1'b1;
        ck(8);
        check("mode3 word count", 32'(rxq3.size()), 32'd2);
        if (rxq3.size() >= 2) begin
            check("mode3 rx word0", 32'(rxq3[0]), 32'h81);
            check("mode3 rx word1", 32'(rxq3[1]), 32'h7E);
        end
        check("mode3 miso word0", 32'(r3[0]), 32'h5A);
        check("mode3 miso word1", 32'(r3[1]), 32'hC3);
        check("mode3 overrun", 32'(ovr_cnt3 - ob), 32'd0);
        check("mode3 busy", 32'(busy3), 32'd0);

        rxr0 = 1'b1;
        ck(2);
        rxq0.delete();
        exp_q.delete();
        ob = ovr_cnt0;
        for (int f = 0; f < 6; f++) begin
            nw = int'($urandom_range(1, 3));
            for (int w = 0; w < nw; w++) begin
                f_mosi[w] = 16'($urandom);
                f_tx[w]   = 16'($urandom);
                f_load[w] = ($urandom_range(0, 1) == 1);
                exp_q.push_back(f_mosi[w]);
            end
            frame0(nw, 1'b0);
            for (int w = 0; w < nw; w++) begin
                em = f_load[w] ? f_tx[w] : 16'h0000;
                check("rand miso word", 32'(f_miso[w]), 32'(em));
            end
        end
        rxr0 = 1'b0;
        check("rand rx count", 32'(rxq0.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rxq0.size(); i++)
            check("rand rx word", 32'(rxq0[i]), 32'(exp_q[i]));
        check("rand overrun", 32'(ovr_cnt0 - ob), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
